// File: rtl/wb_write_arbiter.sv
// Write-back arbiter: buffers results from three functional units in a circular FIFO
// and drains up to two entries per cycle onto the two register-file write ports.
module wb_write_arbiter #(
  parameter int OPRAND_WIDTH  = 32,
  parameter int REGNAME_WIDTH = 5,
  parameter int DEPTH         = 4
) (
  input  logic                          clk,
  input  logic                          rst,

  input  logic                          fu0_valid_i,
  input  logic [OPRAND_WIDTH-1:0]       fu0_data_i,
  input  logic [REGNAME_WIDTH-1:0]      fu0_addr_i,
  output logic                          fu0_ready_o,

  input  logic                          fu1_valid_i,
  input  logic [OPRAND_WIDTH-1:0]       fu1_data_i,
  input  logic [REGNAME_WIDTH-1:0]      fu1_addr_i,
  output logic                          fu1_ready_o,

  input  logic                          fu2_valid_i,
  input  logic [OPRAND_WIDTH-1:0]       fu2_data_i,
  input  logic [REGNAME_WIDTH-1:0]      fu2_addr_i,
  output logic                          fu2_ready_o,

  output logic                          write1_en_o,
  output logic [REGNAME_WIDTH-1:0]      write1_addr_o,
  output logic [OPRAND_WIDTH-1:0]       write1_data_o,

  output logic                          write2_en_o,
  output logic [REGNAME_WIDTH-1:0]      write2_addr_o,
  output logic [OPRAND_WIDTH-1:0]       write2_data_o,

  output logic [$clog2(DEPTH):0]        count_o
);

  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;
  localparam int NFU = 3;

  logic [PW-1:0]            head_q, head_d;
  logic [PW-1:0]            tail_q, tail_d;
  logic [CW-1:0]            count_q, count_d;
  logic [CW-1:0]            free;

  logic [REGNAME_WIDTH-1:0] mem_addr_q [DEPTH];
  logic [OPRAND_WIDTH-1:0]  mem_data_q [DEPTH];

  logic                     fu_valid [NFU];
  logic [REGNAME_WIDTH-1:0] fu_addr  [NFU];
  logic [OPRAND_WIDTH-1:0]  fu_data  [NFU];
  logic                     fu_ready [NFU];
  logic                     keep     [NFU];
  logic [PW-1:0]            wr_idx   [NFU];
  logic [CW-1:0]            n_enq;
  logic [CW-1:0]            n_pop;
  logic [PW-1:0]            head_nxt;
  logic                     w1_en, w2_en;

  assign fu_valid[0] = fu0_valid_i;
  assign fu_valid[1] = fu1_valid_i;
  assign fu_valid[2] = fu2_valid_i;
  assign fu_addr[0]  = fu0_addr_i;
  assign fu_addr[1]  = fu1_addr_i;
  assign fu_addr[2]  = fu2_addr_i;
  assign fu_data[0]  = fu0_data_i;
  assign fu_data[1]  = fu1_data_i;
  assign fu_data[2]  = fu2_data_i;

  // Space is judged on registered occupancy only, so a drain this cycle never frees a slot early.
  assign free = CW'(DEPTH) - count_q;

  always_comb begin
    for (int k = 0; k < NFU; k++) begin
      fu_ready[k] = (free >= CW'(k + 1));
    end
  end

  assign fu0_ready_o = fu_ready[0];
  assign fu1_ready_o = fu_ready[1];
  assign fu2_ready_o = fu_ready[2];

  // Kept results pack into consecutive tail slots in unit order; writes to x0 are discarded.
  always_comb begin
    n_enq = '0;
    for (int k = 0; k < NFU; k++) begin
      keep[k]   = fu_valid[k] && fu_ready[k] && (fu_addr[k] != '0);
      wr_idx[k] = tail_q + PW'(n_enq);
      if (keep[k]) begin
        n_enq = n_enq + CW'(1);
      end
    end
  end

  assign head_nxt = head_q + PW'(1);
  assign w1_en    = (count_q != '0);
  // Same-address pair: let only the older one go so the register ends with the younger value.
  assign w2_en    = (count_q >= CW'(2)) && (mem_addr_q[head_nxt] != mem_addr_q[head_q]);
  assign n_pop    = CW'(w1_en) + CW'(w2_en);

  always_comb begin
    head_d  = head_q + PW'(n_pop);
    tail_d  = tail_q + PW'(n_enq);
    count_d = count_q + n_enq - n_pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry payloads carry no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NFU; k++) begin
      if (keep[k]) begin
        mem_addr_q[wr_idx[k]] <= fu_addr[k];
        mem_data_q[wr_idx[k]] <= fu_data[k];
      end
    end
  end

  assign write1_en_o   = w1_en;
  assign write1_addr_o = w1_en ? mem_addr_q[head_q] : '0;
  assign write1_data_o = w1_en ? mem_data_q[head_q] : '0;

  assign write2_en_o   = w2_en;
  assign write2_addr_o = w2_en ? mem_addr_q[head_nxt] : '0;
  assign write2_data_o = w2_en ? mem_data_q[head_nxt] : '0;

  assign count_o = count_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Scoreboard bench for wb_write_arbiter: stimulus pushes expected writes, a negedge
// monitor pops them as write strobes appear; directed checks cover occupancy and ready.
module tb_wb_write_arbiter;

  localparam int OW = 32;
  localparam int RW = 5;

  typedef struct {
    logic [RW-1:0] addr;
    logic [OW-1:0] data;
  } wr_t;

  logic          clk;
  logic          rst;
  logic          fu0_valid_i, fu1_valid_i, fu2_valid_i;
  logic [OW-1:0] fu0_data_i, fu1_data_i, fu2_data_i;
  logic [RW-1:0] fu0_addr_i, fu1_addr_i, fu2_addr_i;
  logic          fu0_ready_o, fu1_ready_o, fu2_ready_o;
  logic          write1_en_o, write2_en_o;
  logic [RW-1:0] write1_addr_o, write2_addr_o;
  logic [OW-1:0] write1_data_o, write2_data_o;
  logic [2:0]    count_o;

  wr_t exp_q[$];
  int  n_chk  = 0;
  int  n_pass = 0;

  wb_write_arbiter #(.OPRAND_WIDTH(OW), .REGNAME_WIDTH(RW), .DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .fu0_valid_i(fu0_valid_i), .fu0_data_i(fu0_data_i), .fu0_addr_i(fu0_addr_i), .fu0_ready_o(fu0_ready_o),
    .fu1_valid_i(fu1_valid_i), .fu1_data_i(fu1_data_i), .fu1_addr_i(fu1_addr_i), .fu1_ready_o(fu1_ready_o),
    .fu2_valid_i(fu2_valid_i), .fu2_data_i(fu2_data_i), .fu2_addr_i(fu2_addr_i), .fu2_ready_o(fu2_ready_o),
    .write1_en_o(write1_en_o), .write1_addr_o(write1_addr_o), .write1_data_o(write1_data_o),
    .write2_en_o(write2_en_o), .write2_addr_o(write2_addr_o), .write2_data_o(write2_data_o),
    .count_o(count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic push(input logic [RW-1:0] a, input logic [OW-1:0] d);
    wr_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    fu0_valid_i = 0; fu1_valid_i = 0; fu2_valid_i = 0;
    fu0_addr_i = '0; fu1_addr_i = '0; fu2_addr_i = '0;
    fu0_data_i = '0; fu1_data_i = '0; fu2_data_i = '0;
  endtask

  task automatic chk_ready(input string name, input logic r0, input logic r1, input logic r2);
    chk({name, "_rdy0"}, longint'(fu0_ready_o), longint'(r0));
    chk({name, "_rdy1"}, longint'(fu1_ready_o), longint'(r1));
    chk({name, "_rdy2"}, longint'(fu2_ready_o), longint'(r2));
  endtask

  task automatic mon_port(input string name, input logic en, input logic [RW-1:0] a, input logic [OW-1:0] d);
    wr_t e;
    if (en) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL %s_unexpected: got write addr %0d data 0x%0h, want no write", name, a, d);
      end else begin
        e = exp_q.pop_front();
        chk({name, "_addr"}, longint'(a), longint'(e.addr));
        chk({name, "_data"}, longint'(d), longint'(e.data));
      end
    end else begin
      chk({name, "_idle_zero"}, longint'({a, d}), 0);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      mon_port("w1", write1_en_o, write1_addr_o, write1_data_o);
      mon_port("w2", write2_en_o, write2_addr_o, write2_data_o);
    end
  end

  initial begin
    clear_in();
    rst = 1'b1;
    @(posedge clk);
    step();
    chk("rst_count", longint'(count_o), 0);
    chk("rst_w1en", longint'(write1_en_o), 0);
    chk("rst_w2en", longint'(write2_en_o), 0);
    chk("rst_outs", longint'({write1_addr_o, write1_data_o, write2_addr_o, write2_data_o}), 0);
    chk_ready("rst", 1, 1, 1);
    rst = 1'b0;
    step();

    // single result from fu1
    fu1_valid_i = 1; fu1_addr_i = 5'd7; fu1_data_i = 32'hA5;
    push(5'd7, 32'hA5);
    step();
    clear_in();
    chk("single_count", longint'(count_o), 1);
    chk("single_w1en", longint'(write1_en_o), 1);
    chk("single_w2en", longint'(write2_en_o), 0);
    step();
    chk("single_drained", longint'(count_o), 0);

    // triple accept, then fu1 offered while only one slot is free
    fu0_valid_i = 1; fu0_addr_i = 5'd3; fu0_data_i = 32'h30;
    fu1_valid_i = 1; fu1_addr_i = 5'd4; fu1_data_i = 32'h40;
    fu2_valid_i = 1; fu2_addr_i = 5'd5; fu2_data_i = 32'h50;
    push(5'd3, 32'h30); push(5'd4, 32'h40); push(5'd5, 32'h50);
    step();
    clear_in();
    fu1_valid_i = 1; fu1_addr_i = 5'd6; fu1_data_i = 32'h66;
    chk("triple_count", longint'(count_o), 3);
    chk("triple_w2en", longint'(write2_en_o), 1);
    chk_ready("full", 1, 0, 0);
    step();
    clear_in();
    chk("full_reject_count", longint'(count_o), 1);
    step();
    chk("triple_drained", longint'(count_o), 0);

    // same destination twice in one cycle
    fu0_valid_i = 1; fu0_addr_i = 5'd9; fu0_data_i = 32'd1;
    fu1_valid_i = 1; fu1_addr_i = 5'd9; fu1_data_i = 32'd2;
    push(5'd9, 32'd1); push(5'd9, 32'd2);
    step();
    clear_in();
    chk("same_count", longint'(count_o), 2);
    chk("same_w2en", longint'(write2_en_o), 0);
    step();
    chk("same_count_after", longint'(count_o), 1);
    step();
    chk("same_drained", longint'(count_o), 0);

    // write to x0 is dropped
    fu2_valid_i = 1; fu2_addr_i = 5'd0; fu2_data_i = 32'hDEAD;
    chk("x0_rdy2", longint'(fu2_ready_o), 1);
    step();
    clear_in();
    chk("x0_count", longint'(count_o), 0);
    chk("x0_w1en", longint'(write1_en_o), 0);
    step();

    // streaming with wrap-around, mixed accept/reject/drop
    fu0_valid_i = 1; fu0_addr_i = 5'd1; fu0_data_i = 32'd11;
    fu1_valid_i = 1; fu1_addr_i = 5'd2; fu1_data_i = 32'd12;
    fu2_valid_i = 1; fu2_addr_i = 5'd3; fu2_data_i = 32'd13;
    push(5'd1, 32'd11); push(5'd2, 32'd12); push(5'd3, 32'd13);
    step();
    clear_in();
    fu0_valid_i = 1; fu0_addr_i = 5'd4; fu0_data_i = 32'd14;
    fu1_valid_i = 1; fu1_addr_i = 5'd5; fu1_data_i = 32'd15;
    push(5'd4, 32'd14);
    chk("stream_c1_count", longint'(count_o), 3);
    step();
    clear_in();
    fu0_valid_i = 1; fu0_addr_i = 5'd6; fu0_data_i = 32'd16;
    fu1_valid_i = 1; fu1_addr_i = 5'd7; fu1_data_i = 32'd17;
    fu2_valid_i = 1; fu2_addr_i = 5'd8; fu2_data_i = 32'd18;
    push(5'd6, 32'd16); push(5'd7, 32'd17);
    chk("stream_c2_count", longint'(count_o), 2);
    chk_ready("stream_c2", 1, 1, 0);
    step();
    clear_in();
    fu0_valid_i = 1; fu0_addr_i = 5'd0; fu0_data_i = 32'd0;
    fu1_valid_i = 1; fu1_addr_i = 5'd7; fu1_data_i = 32'd19;
    push(5'd7, 32'd19);
    chk("stream_c3_count", longint'(count_o), 2);
    step();
    clear_in();
    chk("stream_c4_count", longint'(count_o), 1);
    step();
    chk("stream_drained", longint'(count_o), 0);

    // reset with two entries in flight
    fu0_valid_i = 1; fu0_addr_i = 5'd10; fu0_data_i = 32'd100;
    fu1_valid_i = 1; fu1_addr_i = 5'd11; fu1_data_i = 32'd101;
    step();
    clear_in();
    chk("midrst_pre_count", longint'(count_o), 2);
    rst = 1'b1;
    #1;
    chk("midrst_count", longint'(count_o), 0);
    chk("midrst_w1en", longint'(write1_en_o), 0);
    chk("midrst_w2en", longint'(write2_en_o), 0);
    chk("midrst_outs", longint'({write1_addr_o, write1_data_o, write2_addr_o, write2_data_o}), 0);
    chk_ready("midrst", 1, 1, 1);
    step();
    rst = 1'b0;
    step();
    chk("postrst_count", longint'(count_o), 0);

    // recovery after reset
    fu0_valid_i = 1; fu0_addr_i = 5'd31; fu0_data_i = 32'hFFFF_FFFF;
    push(5'd31, 32'hFFFF_FFFF);
    step();
    clear_in();
    chk("recover_count", longint'(count_o), 1);
    step();
    step();
    chk("scoreboard_empty", longint'(exp_q.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
